sound_frame_rcv: RTL and testbench
==================================

# sound_frame_rcv

Parametrised multi-byte sound-frame receiver. It takes a serial audio stream on `rx` (8N1 UART, 16x oversampled) and packs the bytes little-endian into `8*WORD_BYTES`-bit words. Words are stored in a two-bank (ping-pong) buffer, and banks swap on each `msec` strobe. The previous frame can then be read randomly by the host bus through `rdaddress`/`q` while the next frame fills. It replaces the single-buffer sound receiver in the aud1 path and adds framing-error detection, overrun reporting and frame-length export.

## Interface
Parameters:
- `CLK_DIV`, 3: clk cycles per oversample tick; baud = f_clk / (16*CLK_DIV); must be ≥2
- `WORD_BYTES`, 4: bytes packed per stored word (1..4)
- `DEPTH_W`, 9: log2 of words per bank (bank = 2^DEPTH_W words)

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset, synchronous, active-high
- `rx`  in  1  async serial input, idle high
- `msec`  in  1  one-cycle frame strobe; triggers a bank swap
- `start`  in  1  capture enable (level)
- `rdaddress`  in  DEPTH_W  word address into the read bank
- `q`  out  8*WORD_BYTES  read data, registered
- `frame_rdy`  out  1  one-cycle pulse after a swap
- `frame_len`  out  DEPTH_W+1  words valid in the read bank
- `overrun`  out  1  sticky per frame: bytes dropped because the bank was full
- `framing_err`  out  1  one-cycle pulse: stop bit sampled low

## Operation
- `rx` passes through a 2-flop synchroniser. The tick divisor counts 0..CLK_DIV-1 and pulses `tick` at the wrap.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge goes to START.
  - START: after 7 ticks, if the line is still low go to DATA, otherwise return to IDLE (glitch).
  - DATA: sample every 16 ticks, LSB first, 8 bits.
  - STOP: sample at 16 ticks. High: byte_done. Low: `framing_err` pulse, byte discarded. Return to IDLE either way.
- Packer: byte_done with `start`=1 places the byte into lane `byte_idx` (lane 0 = bits 7:0). When `byte_idx` reaches WORD_BYTES-1, the word is written at `wr_ptr`, `wr_ptr` increments and `byte_idx` clears.
- Full: if `wr_ptr` = 2^DEPTH_W, the word write is suppressed and `overrun` is set. `wr_ptr` saturates.
- `msec` with `start`=1 (swap):
  - Any partial word is flushed first, zero-padded in the upper lanes, if space remains. It counts in the length.
  - `frame_len` ← final word count; `overrun` ← the overrun flag of the closing frame.
  - Read/write banks toggle; `wr_ptr`, `byte_idx` and the internal overrun flag clear.
  - `frame_rdy` pulses.
- `start`=0: `wr_ptr`, `byte_idx` and the internal overrun flag are held at 0. Bytes are dropped and `msec` is ignored. The read bank and `frame_len` stay unchanged.
- Simultaneous `msec` and byte_done: the swap completes first. The byte becomes lane 0 of the new frame.
- Read: `q` ← read_bank[`rdaddress`] if `rdaddress` < `frame_len`, else 0.

## Timing
- Reset: all outputs 0, both FSMs idle, `frame_len`=0. RAM contents are not cleared; gating by `frame_len` makes them invisible.
- Reset mid-byte or mid-frame: the partial byte, word and frame are discarded. No `frame_rdy` is issued.
- byte_done fires on the STOP-sample tick cycle. The word write happens the next cycle.
- `frame_rdy`, `frame_len` and `overrun` update 2 cycles after `msec`: cycle 1 flushes, cycle 2 swaps. A byte_done arriving during these 2 cycles is held in a 1-entry skid register and is not lost.
- `q` latency: 1 clk from `rdaddress`. Reads are never stalled. The read bank is stable between `frame_rdy` pulses.
- `msec` strobes must be ≥4 cycles apart; closer strobes are ignored.

## Structure
- Shared package `sound_pkg`: RX state enum, `BITS_PER_BYTE`=8, `OVS`=16, `START_MID`=7.
- One sub-module `sound_bank_ram`: simple dual-port RAM, 2^(DEPTH_W+1) x 8*WORD_BYTES, with the bank bit as the address MSB and registered read.
- The RX FSM, tick divisor and packer stay in the top-level module.

## Test plan
- CLK_DIV=3, `start`=1, send 0x11 0x22 0x33 0x44 0x55, then `msec` → `frame_rdy`, `frame_len`=2; addr0 q=0x44332211, addr1 q=0x00000055, addr2 q=0.
- DEPTH_W=2, send 20 bytes then `msec` → `frame_len`=4, `overrun`=1. The next clean frame reports `overrun`=0.
- Byte 0xA5 sent with stop bit low → `framing_err` pulse; after `msec`, `frame_len`=0.
- `msec` in the same cycle as byte_done of 0x77 → the old frame closes without 0x77; the next frame's word0 lane0=0x77.
- Drop `start` after 3 bytes, then `msec` → no `frame_rdy`; the read bank and `frame_len` are unchanged.
- Assert `rst` mid-byte → all outputs 0 the next cycle. The next clean byte is received correctly.

Source files
------------

// File: rtl/sound_pkg.sv
// sound_pkg: shared definitions for the sound frame receiver.
//   - RX FSM state encoding (UART byte receiver)
//   - Bank-swap sequencer state encoding
//   - Serial framing constants
package sound_pkg;

  localparam int BITS_PER_BYTE = 8;   // data bits per UART character
  localparam int OVS           = 16;  // oversample ticks per bit
  localparam int START_MID     = 7;   // ticks into the start bit before re-checking the line

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // SW_FLUSH writes the partial word, SW_SWAP toggles banks, SW_HOLD keeps
  // the next msec out for one more cycle so strobes closer than 4 cycles
  // are ignored.
  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_FLUSH = 2'd1,
    SW_SWAP  = 2'd2,
    SW_HOLD  = 2'd3
  } swap_state_t;

endpackage

// File: rtl/sound_bank_ram.sv
// sound_bank_ram: simple dual-port RAM holding both ping-pong banks.
// The bank select is the MSB of each address.
// Ports:
//   clk    - system clock
//   we     - write enable
//   waddr  - write address {bank, word}
//   wdata  - write data
//   raddr  - read address {bank, word}
//   rdata  - registered read data (1-cycle latency)
// Contents are not initialised; the owner gates reads by a valid length.
module sound_bank_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sound_frame_rcv.sv
// sound_frame_rcv: 8N1 UART (16x oversampled) byte receiver that packs
// bytes little-endian into words and stores them in a ping-pong buffer.
// Banks swap on each accepted msec strobe; the host reads the closed frame.
// Ports:
//   clk         - system clock (single domain)
//   rst         - synchronous active-high reset
//   rx          - asynchronous serial input, idle high
//   msec        - one-cycle frame strobe, requests a bank swap
//   start       - capture enable (level)
//   rdaddress   - word address into the read bank
//   q           - read data, 1-cycle latency, 0 beyond frame_len
//   frame_rdy   - one-cycle pulse when a swap completes
//   frame_len   - number of valid words in the read bank
//   overrun     - closing frame dropped bytes because its bank was full
//   framing_err - one-cycle pulse when a stop bit was sampled low
// The RX FSM state is visible as rx_state / sw_state for checkers.
module sound_frame_rcv
  import sound_pkg::*;
#(
  parameter int CLK_DIV    = 3,
  parameter int WORD_BYTES = 4,
  parameter int DEPTH_W    = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx,
  input  logic                            msec,
  input  logic                            start,
  input  logic [DEPTH_W-1:0]              rdaddress,
  output logic [BITS_PER_BYTE*WORD_BYTES-1:0] q,
  output logic                            frame_rdy,
  output logic [DEPTH_W:0]                frame_len,
  output logic                            overrun,
  output logic                            framing_err
);

  localparam int WORD_W = BITS_PER_BYTE * WORD_BYTES;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  // ---------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ---------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------
  // Oversample tick divisor (free running)
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end

  // ---------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------
  rx_state_t  rx_state, rx_next;
  logic [3:0] tick_cnt, tick_cnt_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [BITS_PER_BYTE-1:0] shift_reg, shift_nx;
  logic       byte_done;
  logic       fe_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= RX_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      framing_err <= 1'b0;
    end else begin
      rx_state    <= rx_next;
      tick_cnt    <= tick_cnt_nx;
      bit_cnt     <= bit_cnt_nx;
      shift_reg   <= shift_nx;
      framing_err <= fe_set;
    end
  end

  always_comb begin
    rx_next     = rx_state;
    tick_cnt_nx = tick_cnt;
    bit_cnt_nx  = bit_cnt;
    shift_nx    = shift_reg;
    byte_done   = 1'b0;
    fe_set      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        tick_cnt_nx = '0;
        bit_cnt_nx  = '0;
        if (rx_prev && !rx_sync) rx_next = RX_START;
      end
      RX_START: begin
        if (tick) begin
          if (tick_cnt == 4'(START_MID - 1)) begin
            tick_cnt_nx = '0;
            // Line back high by mid-start: treat as a glitch.
            rx_next = rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            tick_cnt_nx = tick_cnt + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (tick_cnt == 4'(OVS - 1)) begin
            tick_cnt_nx = '0;
            shift_nx    = {rx_sync, shift_reg[BITS_PER_BYTE-1:1]};
            bit_cnt_nx  = bit_cnt + 3'd1;
            if (bit_cnt == 3'(BITS_PER_BYTE - 1)) rx_next = RX_STOP;
          end else begin
            tick_cnt_nx = tick_cnt + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (tick_cnt == 4'(OVS - 1)) begin
            tick_cnt_nx = '0;
            rx_next     = RX_IDLE;
            if (rx_sync) byte_done = 1'b1;
            else         fe_set    = 1'b1;
          end else begin
            tick_cnt_nx = tick_cnt + 4'd1;
          end
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Swap sequencer
  // ---------------------------------------------------------------------
  swap_state_t sw_state, sw_next;
  logic        accept_msec;

  assign accept_msec = msec && start && (sw_state == SW_IDLE);

  always_ff @(posedge clk) begin
    if (rst) sw_state <= SW_IDLE;
    else     sw_state <= sw_next;
  end

  always_comb begin
    sw_next = sw_state;
    case (sw_state)
      SW_IDLE:  if (accept_msec) sw_next = SW_FLUSH;
      SW_FLUSH: sw_next = SW_SWAP;
      SW_SWAP:  sw_next = SW_HOLD;
      SW_HOLD:  sw_next = SW_IDLE;
      default:  sw_next = SW_IDLE;
    endcase
    if (!start) sw_next = SW_IDLE;
  end

  // ---------------------------------------------------------------------
  // Byte path. byte_done is a valid-only pulse (no backpressure): the
  // packer must take it the cycle it appears or park it in the skid
  // register. From the accepted msec cycle through SW_SWAP the packer is
  // busy closing the frame, so a byte arriving then waits in the skid and
  // is packed as lane 0 of the new frame once the swap has completed.
  // ---------------------------------------------------------------------
  logic                     skid_valid;
  logic [BITS_PER_BYTE-1:0] skid_byte;
  logic                     pack_en, pack_valid;
  logic [BITS_PER_BYTE-1:0] pack_byte;

  assign pack_en    = start && ((sw_state == SW_IDLE) || (sw_state == SW_HOLD)) && !accept_msec;
  assign pack_valid = pack_en && (skid_valid || byte_done);
  assign pack_byte  = skid_valid ? skid_byte : shift_reg;

  always_ff @(posedge clk) begin
    if (rst || !start) begin
      skid_valid <= 1'b0;
      skid_byte  <= '0;
    end else if (pack_en) begin
      if (skid_valid && byte_done) skid_byte <= shift_reg;
      skid_valid <= skid_valid && byte_done;
    end else if (byte_done) begin
      skid_valid <= 1'b1;
      skid_byte  <= shift_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Packer and write port. Writes are registered (we_q/waddr_q/wdata_q)
  // and carry their own bank bit, so a flush issued just before the swap
  // still lands in the closing bank.
  // ---------------------------------------------------------------------
  logic [LANE_W-1:0]  byte_idx;
  logic [WORD_W-1:0]  word_buf, lane_word;
  logic [DEPTH_W:0]   wr_ptr;
  logic               ovr_flag;
  logic               wr_bank;
  logic               we_q;
  logic [DEPTH_W:0]   waddr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic               full, last_lane;

  // wr_ptr saturates at 2^DEPTH_W, so its MSB alone marks a full bank.
  assign full      = wr_ptr[DEPTH_W];
  assign last_lane = (byte_idx == LANE_W'(WORD_BYTES - 1));

  always_comb begin
    lane_word = word_buf;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (LANE_W'(i) == byte_idx) lane_word[i*BITS_PER_BYTE +: BITS_PER_BYTE] = pack_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx  <= '0;
      word_buf  <= '0;
      wr_ptr    <= '0;
      ovr_flag  <= 1'b0;
      wr_bank   <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      frame_len <= '0;
      overrun   <= 1'b0;
      frame_rdy <= 1'b0;
    end else begin
      we_q      <= 1'b0;
      frame_rdy <= 1'b0;
      if (!start) begin
        byte_idx <= '0;
        word_buf <= '0;
        wr_ptr   <= '0;
        ovr_flag <= 1'b0;
      end else begin
        case (sw_state)
          SW_FLUSH: begin
            // Upper lanes of word_buf are already zero (cleared per word).
            if (byte_idx != '0) begin
              if (full) begin
                ovr_flag <= 1'b1;
              end else begin
                we_q    <= 1'b1;
                waddr_q <= {wr_bank, wr_ptr[DEPTH_W-1:0]};
                wdata_q <= word_buf;
                wr_ptr  <= wr_ptr + (DEPTH_W+1)'(1);
              end
            end
          end
          SW_SWAP: begin
            frame_len <= wr_ptr;
            overrun   <= ovr_flag;
            wr_bank   <= ~wr_bank;
            wr_ptr    <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            ovr_flag  <= 1'b0;
            frame_rdy <= 1'b1;
          end
          default: begin
            if (pack_valid) begin
              if (last_lane) begin
                byte_idx <= '0;
                word_buf <= '0;
                if (full) begin
                  ovr_flag <= 1'b1;
                end else begin
                  we_q    <= 1'b1;
                  waddr_q <= {wr_bank, wr_ptr[DEPTH_W-1:0]};
                  wdata_q <= lane_word;
                  wr_ptr  <= wr_ptr + (DEPTH_W+1)'(1);
                end
              end else begin
                byte_idx <= byte_idx + LANE_W'(1);
                word_buf <= lane_word;
              end
            end
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read side: the bank not being written. The length gate is registered
  // alongside the RAM read so both refer to the same frame.
  // ---------------------------------------------------------------------
  logic              rd_ok;
  logic [WORD_W-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (rst) rd_ok <= 1'b0;
    else     rd_ok <= ({1'b0, rdaddress} < frame_len);
  end

  sound_bank_ram #(
    .ADDR_W (DEPTH_W + 1),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (we_q),
    .waddr (waddr_q),
    .wdata (wdata_q),
    .raddr ({~wr_bank, rdaddress}),
    .rdata (ram_q)
  );

  assign q = rd_ok ? ram_q : '0;

endmodule

// File: tb/tb_sound_frame_rcv.sv
// tb_sound_frame_rcv: directed bench for sound_frame_rcv.
// Two instances share rx/msec/start/rst: dut (DEPTH_W=9) and dut_small
// (DEPTH_W=2, 4-word banks) so the full-bank case runs on the same stream.
module tb_sound_frame_rcv;

  localparam int BIT_CLKS = 48;  // 16 ticks * CLK_DIV 3

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rx, msec, start;
  logic [8:0]  rdaddress;
  logic [31:0] q_a, q_b;
  logic        frame_rdy_a, frame_rdy_b;
  logic [9:0]  frame_len_a;
  logic [2:0]  frame_len_b;
  logic        overrun_a, overrun_b, fe_a, fe_b;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int rdy_a = 0, rdy_b = 0, fe_cnt_a = 0, fe_cnt_b = 0;
  int old_rdy_a, old_rdy_b, old_fe_a, old_fe_b;
  bit bd_found;

  sound_frame_rcv #(.CLK_DIV(3), .WORD_BYTES(4), .DEPTH_W(9)) dut (
    .clk(clk), .rst(rst), .rx(rx), .msec(msec), .start(start),
    .rdaddress(rdaddress), .q(q_a), .frame_rdy(frame_rdy_a),
    .frame_len(frame_len_a), .overrun(overrun_a), .framing_err(fe_a)
  );

  sound_frame_rcv #(.CLK_DIV(3), .WORD_BYTES(4), .DEPTH_W(2)) dut_small (
    .clk(clk), .rst(rst), .rx(rx), .msec(msec), .start(start),
    .rdaddress(rdaddress[1:0]), .q(q_b), .frame_rdy(frame_rdy_b),
    .frame_len(frame_len_b), .overrun(overrun_b), .framing_err(fe_b)
  );

  // pulse counters (count cycles high, so a one-cycle pulse adds exactly 1)
  always @(posedge clk) begin
    if (frame_rdy_a) rdy_a    <= rdy_a + 1;
    if (frame_rdy_b) rdy_b    <= rdy_b + 1;
    if (fe_a)        fe_cnt_a <= fe_cnt_a + 1;
    if (fe_b)        fe_cnt_b <= fe_cnt_b + 1;
  end

  // watchdog
  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within 200000 cycles");
    $fatal(1, "watchdog expired");
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(BIT_CLKS);
    end
    rx = stop_bit;
    idle(BIT_CLKS);
    rx = 1'b1;
    idle(16);
  endtask

  task automatic pulse_msec();
    msec = 1'b1;
    @(negedge clk);
    msec = 1'b0;
  endtask

  task automatic snap_rdy();
    old_rdy_a = rdy_a;
    old_rdy_b = rdy_b;
  endtask

  task automatic read_chk(input string tag, input logic [8:0] addr,
                          input logic [31:0] exp_a, input logic [31:0] exp_b);
    rdaddress = addr;
    @(negedge clk);
    check({tag, "_q_a"}, q_a, exp_a);
    check({tag, "_q_b"}, q_b, exp_b);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; msec = 1'b0; start = 1'b1; rdaddress = '0;
    idle(3);

    // reset state
    check("rst_q_a",         q_a, 32'h0);
    check("rst_frame_len_a", 32'(frame_len_a), 32'd0);
    check("rst_frame_rdy_a", 32'(frame_rdy_a), 32'd0);
    check("rst_overrun_a",   32'(overrun_a), 32'd0);
    check("rst_fe_a",        32'(fe_a), 32'd0);
    check("rst_frame_len_b", 32'(frame_len_b), 32'd0);
    rst = 1'b0;
    idle(20);

    // 1: five bytes -> one full word plus a zero-padded partial word
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    snap_rdy();
    pulse_msec();
    idle(6);
    check("t1_rdy_a", 32'(rdy_a - old_rdy_a), 32'd1);
    check("t1_rdy_b", 32'(rdy_b - old_rdy_b), 32'd1);
    check("t1_len_a", 32'(frame_len_a), 32'd2);
    check("t1_len_b", 32'(frame_len_b), 32'd2);
    check("t1_ovr_a", 32'(overrun_a), 32'd0);
    read_chk("t1_a0", 9'd0, 32'h44332211, 32'h44332211);
    read_chk("t1_a1", 9'd1, 32'h00000055, 32'h00000055);
    read_chk("t1_a2", 9'd2, 32'h0, 32'h0);

    // 2: 20 bytes -> small bank overflows on the fifth word
    for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b1);
    snap_rdy();
    pulse_msec();
    idle(6);
    check("t2_rdy_a", 32'(rdy_a - old_rdy_a), 32'd1);
    check("t2_len_a", 32'(frame_len_a), 32'd5);
    check("t2_len_b", 32'(frame_len_b), 32'd4);
    check("t2_ovr_a", 32'(overrun_a), 32'd0);
    check("t2_ovr_b", 32'(overrun_b), 32'd1);
    read_chk("t2_a3", 9'd3, 32'h0F0E0D0C, 32'h0F0E0D0C);
    read_chk("t2_a4", 9'd4, 32'h13121110, 32'h03020100);

    // 2b: clean frame after overrun; second msec 2 cycles later is ignored
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    snap_rdy();
    pulse_msec();
    @(negedge clk);
    pulse_msec();
    idle(8);
    check("t2b_rdy_a", 32'(rdy_a - old_rdy_a), 32'd1);
    check("t2b_rdy_b", 32'(rdy_b - old_rdy_b), 32'd1);
    check("t2b_len_b", 32'(frame_len_b), 32'd1);
    check("t2b_ovr_b", 32'(overrun_b), 32'd0);
    read_chk("t2b_a0", 9'd0, 32'h0000CDAB, 32'h0000CDAB);
    read_chk("t2b_a1", 9'd1, 32'h0, 32'h0);

    // 3: framing error, byte discarded
    old_fe_a = fe_cnt_a;
    old_fe_b = fe_cnt_b;
    send_byte(8'hA5, 1'b0);
    idle(4);
    check("t3_fe_a", 32'(fe_cnt_a - old_fe_a), 32'd1);
    check("t3_fe_b", 32'(fe_cnt_b - old_fe_b), 32'd1);
    snap_rdy();
    pulse_msec();
    idle(6);
    check("t3_rdy_a", 32'(rdy_a - old_rdy_a), 32'd1);
    check("t3_len_a", 32'(frame_len_a), 32'd0);
    check("t3_len_b", 32'(frame_len_b), 32'd0);
    read_chk("t3_a0", 9'd0, 32'h0, 32'h0);

    // 4: msec coincides with byte_done of 0x77
    send_byte(8'h66, 1'b1);
    snap_rdy();
    bd_found = 1'b0;
    fork
      send_byte(8'h77, 1'b1);
      begin
        for (int i = 0; i < 1000 && !bd_found; i++) begin
          @(negedge clk);
          if (dut.byte_done) bd_found = 1'b1;
        end
        if (bd_found) pulse_msec();
      end
    join
    idle(4);
    check("t4_bd_seen", 32'(bd_found), 32'd1);
    check("t4_rdy_a", 32'(rdy_a - old_rdy_a), 32'd1);
    check("t4_len_a", 32'(frame_len_a), 32'd1);
    check("t4_len_b", 32'(frame_len_b), 32'd1);
    read_chk("t4_old_a0", 9'd0, 32'h00000066, 32'h00000066);
    pulse_msec();
    idle(6);
    check("t4_new_len_a", 32'(frame_len_a), 32'd1);
    read_chk("t4_new_a0", 9'd0, 32'h00000077, 32'h00000077);

    // 5: drop start after 3 bytes; msec ignored, read side frozen
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    start = 1'b0;
    idle(2);
    snap_rdy();
    pulse_msec();
    idle(8);
    check("t5_rdy_a", 32'(rdy_a - old_rdy_a), 32'd0);
    check("t5_rdy_b", 32'(rdy_b - old_rdy_b), 32'd0);
    check("t5_len_a", 32'(frame_len_a), 32'd1);
    read_chk("t5_a0", 9'd0, 32'h00000077, 32'h00000077);
    start = 1'b1;
    idle(4);
    send_byte(8'h5A, 1'b1);
    pulse_msec();
    idle(6);
    check("t5_after_len_a", 32'(frame_len_a), 32'd1);
    read_chk("t5_after_a0", 9'd0, 32'h0000005A, 32'h0000005A);

    // 6: reset mid-byte
    rdaddress = 9'd0;
    idle(2);
    check("t6_pre_q_a", q_a, 32'h0000005A);
    rx = 1'b0;
    idle(BIT_CLKS);
    rx = 1'b1;
    idle(20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_q_a",         q_a, 32'h0);
    check("t6_frame_len_a", 32'(frame_len_a), 32'd0);
    check("t6_frame_rdy_a", 32'(frame_rdy_a), 32'd0);
    check("t6_overrun_a",   32'(overrun_a), 32'd0);
    check("t6_fe_a",        32'(fe_a), 32'd0);
    check("t6_q_b",         q_b, 32'h0);
    idle(10 * BIT_CLKS);
    send_byte(8'hC3, 1'b1);
    snap_rdy();
    pulse_msec();
    idle(6);
    check("t6_rdy_a", 32'(rdy_a - old_rdy_a), 32'd1);
    check("t6_len_a", 32'(frame_len_a), 32'd1);
    read_chk("t6_a0", 9'd0, 32'h000000C3, 32'h000000C3);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
